// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for the N-to-1 mux/arbiter: per-channel inputs with valid/ready,
// plus one registered output with valid/ready and source index.
interface mux_arb_nto1_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4
);
  localparam int unsigned SW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SW-1:0]      sel;
  logic               mode;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_src;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out, out_valid, out_src
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 multiplexer/arbiter: select or round-robin choice of one channel into a
// single registered output stage with valid/ready flow control.
module mux_arb_nto1 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_arb_nto1_if.slave  bus
);
  localparam int unsigned SW = $clog2(N);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    cand;
  logic [SW-1:0]    idx_s;
  logic             hit;
  logic             open;
  logic             take;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] out_q;
  logic [SW-1:0]    src_q;
  logic             valid_q;

  // Candidate selection; round-robin scans ptr+1 .. ptr+N modulo N.
  always_comb begin
    hit   = 1'b0;
    cand  = '0;
    idx_s = '0;
    if (!bus.mode) begin
      if (32'(bus.sel) < N) begin
        cand = bus.sel;
        hit  = bus.in_valid[bus.sel];
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx_s = SW'((32'(ptr) + k) % N);
        if (!hit && bus.in_valid[idx_s]) begin
          hit  = 1'b1;
          cand = idx_s;
        end
      end
    end
  end

  assign open = !valid_q || bus.out_ready;
  assign take = rst_n && open && hit;

  always_comb begin
    grant = '0;
    if (take) grant[cand] = 1'b1;
  end

  assign bus.in_ready  = grant;
  assign bus.out       = out_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= SW'(N - 1);
    end else if (take) begin
      out_q   <= bus.in_data[cand*WIDTH +: WIDTH];
      src_q   <= cand;
      valid_q <= 1'b1;
      ptr     <= cand;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1 (N=4, WIDTH=4): stimulus pushes expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_mux_arb_nto1;
  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  localparam logic [3:0] A = 4'h3;
  localparam logic [3:0] B = 4'h5;
  localparam logic [3:0] C = 4'h9;
  localparam logic [3:0] D = 4'hC;

  typedef struct {
    logic [3:0] data;
    logic [1:0] src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  mux_arb_nto1_if #(.WIDTH(W), .N(N)) bus ();
  mux_arb_nto1 #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, check the grant, queue the expected word if granted.
  task automatic issue(input string name, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic r, input logic [3:0] exp_rdy,
                       input logic [3:0] exp_data, input logic [1:0] exp_src);
    exp_t e;
    bus.mode      = m;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = r;
    #1;
    chk(name, 32'(bus.in_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      e.data = exp_data;
      e.src  = exp_src;
      q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=no_word", bus.out);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(bus.out), 32'(e.data));
          chk("out_src", 32'(bus.out_src), 32'(e.src));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.in_data   = {D, C, B, A};
    bus.in_valid  = 4'b1111;
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_out_src", 32'(bus.out_src), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Select mode stepping sel 0..3
    issue("sel0", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, A, 2'd0);
    issue("sel1", 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, B, 2'd1);
    issue("sel2", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, C, 2'd2);
    issue("sel3", 1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, D, 2'd3);
    issue("sel_idle", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0, 2'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 0);
    chk("drain_out_hold", 32'(bus.out), 32'(D));

    // Round-robin after a fresh reset starts at channel 0
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    issue("rr0", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, A, 2'd0);
    chk("rr_ov1", 32'(bus.out_valid), 1);
    issue("rr1", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, B, 2'd1);
    chk("rr_ov2", 32'(bus.out_valid), 1);
    issue("rr2", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, C, 2'd2);
    chk("rr_ov3", 32'(bus.out_valid), 1);
    issue("rr3", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, D, 2'd3);
    chk("rr_ov4", 32'(bus.out_valid), 1);
    issue("rr4", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, A, 2'd0);
    chk("rr_ov5", 32'(bus.out_valid), 1);

    // Sparse round-robin: valid 1010 skips 0 and 2
    issue("rr_sp1", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, B, 2'd1);
    issue("rr_sp3", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, D, 2'd3);
    issue("rr_sp1b", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, B, 2'd1);
    issue("rr_sp3b", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, D, 2'd3);
    issue("rr_idle", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0, 2'd0);
    chk("rr_drain_ov", 32'(bus.out_valid), 0);

    // Stall with sel changing, then drain and reload in the same cycle
    issue("st_load", 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, B, 2'd1);
    issue("st_hold1", 1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 4'h0, 2'd0);
    chk("st_out1", 32'(bus.out), 32'(B));
    issue("st_hold2", 1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 4'h0, 2'd0);
    chk("st_out2", 32'(bus.out), 32'(B));
    issue("st_hold3", 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 4'h0, 2'd0);
    chk("st_out3", 32'(bus.out), 32'(B));
    chk("st_src3", 32'(bus.out_src), 1);
    chk("st_ov3", 32'(bus.out_valid), 1);
    issue("st_release", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, C, 2'd2);
    chk("st_ov_after", 32'(bus.out_valid), 1);
    issue("st_idle", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0, 2'd0);

    // Selected channel not valid: no grant, output drains
    issue("nv_load", 1'b0, 2'd0, 4'b1011, 1'b1, 4'b0001, A, 2'd0);
    issue("nv_sel2", 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 4'h0, 2'd0);
    chk("nv_ov", 32'(bus.out_valid), 0);

    // Asynchronous reset while a word is stalled
    issue("ar_load", 1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, D, 2'd3);
    issue("ar_stall", 1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 4'h0, 2'd0);
    chk("ar_ov_before", 32'(bus.out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(bus.out_valid), 0);
    chk("ar_out", 32'(bus.out), 0);
    chk("ar_src", 32'(bus.out_src), 0);
    chk("ar_in_ready", 32'(bus.in_ready), 0);
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    issue("ar_rr0", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, A, 2'd0);
    issue("ar_idle", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'h0, 2'd0);
    chk("end_ov", 32'(bus.out_valid), 0);
    @(posedge clk);
    #2;
    chk("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
